// File: rtl/dma_bus_arbiter_mod_pkg.sv
// Shared CPU-side constants for the OAM DMA block: engine state encoding,
// high-RAM window and default register/destination addresses.
package dma_bus_arbiter_mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] HRAM_LO          = 16'hFF80;
  localparam logic [15:0] HRAM_HI          = 16'hFFFE;
  localparam int unsigned DEF_DMA_LEN      = 160;
  localparam logic [15:0] DEF_DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] DEF_OAM_BASE     = 16'hFE00;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_mod_engine.sv
// OAM DMA engine: sequencing state, byte counter, source page and the
// byte held between the read and write halves of each copy step.
module oam_dma_engine_mod
  import dma_bus_arbiter_mod_pkg::*;
#(
  parameter int unsigned DMA_LEN = DEF_DMA_LEN
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] start_hi,
  input  logic       hold,
  input  logic [7:0] mem_rdata,
  output dma_state_e state,
  output logic [7:0] byte_idx,
  output logic [7:0] src_hi,
  output logic [7:0] dma_data,
  output logic       active
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] byte_idx_q, byte_idx_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] dma_data_q, dma_data_d;
  logic       active_q, active_d;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    src_hi_d   = src_hi_q;
    dma_data_d = dma_data_q;
    // A trigger write restarts from any state; an HRAM cycle freezes progress.
    if (start) begin
      src_hi_d   = start_hi;
      byte_idx_d = 8'd0;
      state_d    = ST_SETUP;
    end else if (!hold) begin
      case (state_q)
        ST_SETUP: state_d = ST_READ;
        ST_READ: begin
          dma_data_d = mem_rdata;
          state_d    = ST_WRITE;
        end
        ST_WRITE: begin
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = 8'd0;
            state_d    = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
            state_d    = ST_READ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= 8'd0;
      src_hi_q   <= 8'h00;
      dma_data_q <= 8'h00;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      src_hi_q   <= src_hi_d;
      dma_data_q <= dma_data_d;
      active_q   <= active_d;
    end
  end

  assign state    = state_q;
  assign byte_idx = byte_idx_q;
  assign src_hi   = src_hi_q;
  assign dma_data = dma_data_q;
  assign active   = active_q;

endmodule

// File: rtl/dma_bus_arbiter_mod.sv
// CPU / OAM-DMA bus arbiter: owns the shared memory bus mux and decides,
// cycle by cycle, whether the CPU or the DMA engine drives it.
module dma_bus_arbiter_mod
  import dma_bus_arbiter_mod_pkg::*;
#(
  parameter int unsigned DMA_LEN      = DEF_DMA_LEN,
  parameter logic [15:0] DMA_REG_ADDR = DEF_DMA_REG_ADDR,
  parameter logic [15:0] OAM_BASE     = DEF_OAM_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  logic       cpu_acc, reg_hit, hram_hit, start;
  dma_state_e state;
  logic [7:0] byte_idx, src_hi, dma_data;

  assign cpu_acc  = cpu_rd | cpu_wr;
  assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
  assign hram_hit = cpu_acc && is_hram(cpu_addr);
  assign start    = cpu_wr && reg_hit;

  oam_dma_engine_mod #(
    .DMA_LEN (DMA_LEN)
  ) u_engine (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .start_hi  (cpu_wdata),
    .hold      (hram_hit),
    .mem_rdata (mem_rdata),
    .state     (state),
    .byte_idx  (byte_idx),
    .src_hi    (src_hi),
    .dma_data  (dma_data),
    .active    (dma_active)
  );

  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = cpu_wr & ~reg_hit;
    mem_wdata = cpu_wdata;
    cpu_rdata = reg_hit ? src_hi : mem_rdata;
    cpu_wait  = 1'b0;
    // DMA owns the bus unless the CPU is touching HRAM this cycle.
    if (dma_active && !hram_hit) begin
      mem_addr  = {src_hi, byte_idx};
      mem_we    = 1'b0;
      mem_wdata = dma_data;
      if (!reg_hit) begin
        cpu_rdata = 8'hFF;
        cpu_wait  = cpu_acc;
      end
      if (state == ST_WRITE) begin
        mem_addr = OAM_BASE + {8'h00, byte_idx};
        mem_we   = 1'b1;
      end
    end
  end

endmodule
